alu_overflow_unit: RTL and testbench

Parametrised, registered overflow detector and trap requester for the EX stage of the 5-stage pipeline. Computes signed overflow for add/sub/slt on WIDTH-bit operands, registers the flag into the EX/MEM boundary under stall/flush control, and raises a held exception request with the faulting PC to the hazard/exception controller until acknowledged. It also maintains a saturating overflow event counter for debug.

---
 rtl/alu_overflow_unit_if.sv | 36 +++
 rtl/alu_overflow_unit.sv | 122 ++++++++++++
 tb/tb_alu_overflow_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_overflow_unit_if.sv
// EX-stage overflow unit bus: operand/control inputs from the pipeline,
// overflow flag, exception request and debug count back out.
interface alu_overflow_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [2:0]       alu_ctr;
  logic             trap_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [31:0]      pc;
  logic             stall;
  logic             flush;
  logic             exc_ack;
  logic             cnt_clr;
  logic             ovf;
  logic             exc_req;
  logic [31:0]      exc_pc;
  logic [CNT_W-1:0] ovf_count;

  // Pipeline / controller side
  modport master (
    output in_valid, alu_ctr, trap_en, a, b, result, pc,
           stall, flush, exc_ack, cnt_clr,
    input  ovf, exc_req, exc_pc, ovf_count
  );

  // Overflow unit side
  modport slave (
    input  in_valid, alu_ctr, trap_en, a, b, result, pc,
           stall, flush, exc_ack, cnt_clr,
    output ovf, exc_req, exc_pc, ovf_count
  );
endinterface

// File: rtl/alu_overflow_unit.sv
// Signed overflow detector for the EX stage: registers the flag into
// EX/MEM, holds a trap request with the faulting PC until acknowledged,
// and keeps a saturating overflow event counter for debug.
module alu_overflow_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 8,
  parameter bit          TRAP_ON_SLT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_overflow_unit_if.slave  bus
);

  localparam logic [2:0]       OP_ADD  = 3'b010;
  localparam logic [2:0]       OP_SUB  = 3'b110;
  localparam logic [2:0]       OP_SLT  = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ovf_c;
  logic             accept;
  logic             trap;
  logic             pc_load;
  logic             ovf_q;
  logic [31:0]      exc_pc_q;
  logic [CNT_W-1:0] cnt_q;

  // Signed overflow from operand and result sign bits
  always_comb begin
    logic sa;
    logic sb;
    logic sr;
    sa    = bus.a[WIDTH-1];
    sb    = bus.b[WIDTH-1];
    sr    = bus.result[WIDTH-1];
    ovf_c = 1'b0;
    case (bus.alu_ctr)
      OP_ADD:         ovf_c = (sa == sb) && (sr != sa);
      OP_SUB, OP_SLT: ovf_c = (sa != sb) && (sr != sa);
      default:        ovf_c = 1'b0;
    endcase
  end

  // Instruction actually leaves EX this cycle; slt may be barred from trapping
  always_comb begin
    accept = bus.in_valid & ~bus.stall & ~bus.flush;
    trap   = accept & ovf_c & bus.trap_en &
             ((bus.alu_ctr != OP_SLT) | TRAP_ON_SLT);
  end

  // EX/MEM overflow flag: flush clears, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
    end else if (!bus.stall) begin
      ovf_q <= bus.in_valid & ovf_c;
    end
  end

  // Exception FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; traps seen while PEND (ack cycle included) are dropped
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap) begin
          state_d = PEND;
          pc_load = 1'b1;
        end
      end
      PEND: begin
        if (bus.exc_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Faulting PC: captured only on the IDLE->PEND transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_pc_q <= '0;
    end else if (pc_load) begin
      exc_pc_q <= bus.pc;
    end
  end

  // Saturating overflow event counter, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && ovf_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.ovf       = ovf_q;
  assign bus.exc_req   = (state_q == PEND);
  assign bus.exc_pc    = exc_pc_q;
  assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_overflow_unit.sv
// Scoreboard bench: three configurations (default, slt-traps, 2-bit
// counter) driven one at a time with directed, hand-computed vectors.
module tb_alu_overflow_unit;

  logic clk;
  logic rst_n;

  alu_overflow_unit_if #(.WIDTH(32), .CNT_W(8)) if0 ();
  alu_overflow_unit_if #(.WIDTH(32), .CNT_W(8)) if1 ();
  alu_overflow_unit_if #(.WIDTH(32), .CNT_W(2)) if2 ();

  alu_overflow_unit #(.WIDTH(32), .CNT_W(8), .TRAP_ON_SLT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  alu_overflow_unit #(.WIDTH(32), .CNT_W(8), .TRAP_ON_SLT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_overflow_unit #(.WIDTH(32), .CNT_W(2), .TRAP_ON_SLT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    string       name;
    logic        ovf;
    logic        req;
    logic [31:0] epc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;
  localparam logic [2:0] SLT = 3'b111;
  localparam logic [2:0] AND = 3'b000;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_all();
    if0.in_valid = 0; if0.alu_ctr = 0; if0.trap_en = 0; if0.a = 0; if0.b = 0;
    if0.result = 0; if0.pc = 0; if0.stall = 0; if0.flush = 0; if0.exc_ack = 0;
    if0.cnt_clr = 0;
    if1.in_valid = 0; if1.alu_ctr = 0; if1.trap_en = 0; if1.a = 0; if1.b = 0;
    if1.result = 0; if1.pc = 0; if1.stall = 0; if1.flush = 0; if1.exc_ack = 0;
    if1.cnt_clr = 0;
    if2.in_valid = 0; if2.alu_ctr = 0; if2.trap_en = 0; if2.a = 0; if2.b = 0;
    if2.result = 0; if2.pc = 0; if2.stall = 0; if2.flush = 0; if2.exc_ack = 0;
    if2.cnt_clr = 0;
  endtask

  // Drive one cycle of inputs on DUT d and queue the post-edge expectation
  task automatic step(input int d, input string name, input logic v,
                      input logic [2:0] op, input logic te,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] pc,
                      input logic st, input logic fl, input logic ack,
                      input logic clr, input logic e_ovf, input logic e_req,
                      input logic [31:0] e_pc, input logic [7:0] e_cnt);
    exp_t e;
    @(negedge clk);
    idle_all();
    case (d)
      0: begin
        if0.in_valid = v; if0.alu_ctr = op; if0.trap_en = te; if0.a = a;
        if0.b = b; if0.result = r; if0.pc = pc; if0.stall = st;
        if0.flush = fl; if0.exc_ack = ack; if0.cnt_clr = clr;
      end
      1: begin
        if1.in_valid = v; if1.alu_ctr = op; if1.trap_en = te; if1.a = a;
        if1.b = b; if1.result = r; if1.pc = pc; if1.stall = st;
        if1.flush = fl; if1.exc_ack = ack; if1.cnt_clr = clr;
      end
      default: begin
        if2.in_valid = v; if2.alu_ctr = op; if2.trap_en = te; if2.a = a;
        if2.b = b; if2.result = r; if2.pc = pc; if2.stall = st;
        if2.flush = fl; if2.exc_ack = ack; if2.cnt_clr = clr;
      end
    endcase
    e.dut = d; e.name = name; e.ovf = e_ovf; e.req = e_req;
    e.epc = e_pc; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, compare just after the edge
  always @(posedge clk) begin
    exp_t        e;
    logic        o;
    logic        q;
    logic [31:0] p;
    logic [7:0]  c;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin o = if0.ovf; q = if0.exc_req; p = if0.exc_pc; c = if0.ovf_count; end
        1:       begin o = if1.ovf; q = if1.exc_req; p = if1.exc_pc; c = if1.ovf_count; end
        default: begin o = if2.ovf; q = if2.exc_req; p = if2.exc_pc;
                       c = {6'b0, if2.ovf_count}; end
      endcase
      check({e.name, ".ovf"}, {31'b0, o}, {31'b0, e.ovf});
      check({e.name, ".exc_req"}, {31'b0, q}, {31'b0, e.req});
      if (e.req) check({e.name, ".exc_pc"}, p, e.epc);
      check({e.name, ".ovf_count"}, {24'b0, c}, {24'b0, e.cnt});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
  localparam logic [31:0] MINN = 32'h8000_0000;

  initial begin
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      d name    v op  te a     b  r     pc           st fl ak cl  ovf req epc          cnt
    step(0, "rst",    0, ADD, 0, 0,    0, 0,    0,            0, 0, 0, 0, 0, 0, 0,            0);
    step(0, "addtrp", 1, ADD, 1, MAXP, 1, MINN, 32'h0040_0010, 0, 0, 0, 0, 1, 1, 32'h0040_0010, 1);
    for (int unsigned i = 0; i < 5; i++)
      step(0, "hold", 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0010, 1);
    step(0, "ack",    0, ADD, 0, 0,    0, 0,    0,            0, 0, 1, 0, 0, 0, 0,            1);
    step(0, "subu",   1, SUB, 0, MINN, 1, MAXP, 32'h20,       0, 0, 0, 0, 1, 0, 0,            2);
    step(0, "subok",  1, SUB, 1, 5,    3, 2,    32'h24,       0, 0, 0, 0, 0, 0, 0,            2);
    step(0, "slt0",   1, SLT, 1, MINN, 1, MAXP, 32'h50,       0, 0, 0, 0, 1, 0, 0,            3);
    step(0, "pend1",  1, ADD, 1, MAXP, 1, MINN, 32'h100,      0, 0, 0, 0, 1, 1, 32'h100,      4);
    step(0, "pend2",  1, ADD, 1, MAXP, 1, MINN, 32'h104,      0, 0, 0, 0, 1, 1, 32'h100,      5);
    step(0, "ackrt",  1, ADD, 1, MAXP, 1, MINN, 32'h108,      0, 0, 1, 0, 1, 0, 0,            6);
    step(0, "noarm",  0, ADD, 0, 0,    0, 0,    0,            0, 0, 0, 0, 0, 0, 0,            6);
    step(0, "ovf1",   1, ADD, 0, MAXP, 1, MINN, 32'h200,      0, 0, 0, 0, 1, 0, 0,            7);
    step(0, "ovf0",   1, ADD, 0, 1,    1, 2,    32'h204,      0, 0, 0, 0, 0, 0, 0,            7);
    step(0, "stl0",   1, ADD, 1, MAXP, 1, MINN, 32'h208,      1, 0, 0, 0, 0, 0, 0,            7);
    step(0, "ovf1b",  1, ADD, 0, MAXP, 1, MINN, 32'h20C,      0, 0, 0, 0, 1, 0, 0,            8);
    step(0, "stl1",   1, ADD, 0, 1,    1, 2,    32'h210,      1, 0, 0, 0, 1, 0, 0,            8);
    step(0, "flush",  1, ADD, 1, MAXP, 1, MINN, 32'h214,      0, 1, 0, 0, 0, 0, 0,            8);
    step(0, "flstl",  1, ADD, 1, MAXP, 1, MINN, 32'h218,      1, 1, 0, 0, 0, 0, 0,            8);
    step(0, "novld",  0, ADD, 1, MAXP, 1, MINN, 32'h21C,      0, 0, 0, 0, 0, 0, 0,            8);
    step(0, "otherop",1, AND, 1, MAXP, 1, MINN, 32'h220,      0, 0, 0, 0, 0, 0, 0,            8);
    step(0, "trp300", 1, ADD, 1, MAXP, 1, MINN, 32'h300,      0, 0, 0, 0, 1, 1, 32'h300,      9);
    step(0, "pend",   0, ADD, 0, 0,    0, 0,    0,            0, 0, 0, 0, 0, 1, 32'h300,      9);

    // Asynchronous reset mid-PEND, checked before any clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.ovf", {31'b0, if0.ovf}, 32'h0);
    check("arst.exc_req", {31'b0, if0.exc_req}, 32'h0);
    check("arst.exc_pc", if0.exc_pc, 32'h0);
    check("arst.ovf_count", {24'b0, if0.ovf_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, "postrst",0, ADD, 0, 0,    0, 0,    0,            0, 0, 0, 0, 0, 0, 0,            0);

    // slt may trap when enabled
    step(1, "slt1",   1, SLT, 1, MINN, 1, MAXP, 32'h500,      0, 0, 0, 0, 1, 1, 32'h500,      1);
    step(1, "slt1ak", 0, ADD, 0, 0,    0, 0,    0,            0, 0, 1, 0, 0, 0, 0,            1);

    // 2-bit counter saturation and clear-with-overflow
    step(2, "sat1",   1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 0, 1, 0, 0,            1);
    step(2, "sat2",   1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 0, 1, 0, 0,            2);
    step(2, "sat3",   1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 0, 1, 0, 0,            3);
    step(2, "sat4",   1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 0, 1, 0, 0,            3);
    step(2, "sat5",   1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 0, 1, 0, 0,            3);
    step(2, "clr",    1, ADD, 0, MAXP, 1, MINN, 0,            0, 0, 0, 1, 1, 0, 0,            0);
    step(2, "aftclr", 1, SUB, 0, MINN, 1, MAXP, 0,            0, 0, 0, 0, 1, 0, 0,            1);

    @(negedge clk);
    idle_all();
    for (int unsigned i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
